mul_share_arb: RTL and testbench
================================

MUL_SHARE_ARB -- requirements
Module: mul_share_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one 6x6 unsigned multiplier.
REQ-002 SHALL have parameter OPW, default 6, operand width; product width is 2*OPW.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester request valid.
REQ-006 SHALL have port req_ready  output  N_REQ  per-requester accept, one-hot or zero.
REQ-007 SHALL have port req_a  input  N_REQ*OPW  packed operand A; requester i at [i*OPW +: OPW].
REQ-008 SHALL have port req_b  input  N_REQ*OPW  packed operand B, same packing.
REQ-009 SHALL have port rsp_valid  output  1  result valid.
REQ-010 SHALL have port rsp_ready  input  1  result consumer ready.
REQ-011 SHALL have port rsp_id  output  clog2(N_REQ)  index of requester owning the result.
REQ-012 SHALL have port rsp_prod  output  2*OPW  unsigned product A*B.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, HOLD.
REQ-015 IDLE: if any req_valid, SHALL assert req_ready for exactly one granted index g for that cycle, latch req_a/req_b of g and g, and go to CALC; else stay IDLE with req_ready all zero.
REQ-016 Grant SHALL be round-robin: lowest index i with req_valid[i], searched from rr_ptr upward, wrapping N_REQ-1 -> 0.
REQ-017 On grant, rr_ptr SHALL become (g+1) mod N_REQ.
REQ-018 CALC: SHALL register latched A*B (full 2*OPW bits, no truncation) into rsp_prod and go to HOLD; req_ready all zero.
REQ-019 HOLD: rsp_valid SHALL be high; rsp_prod and rsp_id SHALL be stable until rsp_ready sampled high, then go to IDLE with rsp_valid low next cycle.
REQ-020 Latency: request accepted in cycle T SHALL give rsp_valid in cycle T+2; minimum issue interval 3 cycles.
REQ-021 req_ready SHALL be zero in CALC and HOLD; requests arriving then SHALL wait, not be dropped.
REQ-022 A requester SHALL hold req_valid and operands until its req_ready; withdrawn requests SHALL simply not be granted.
REQ-023 rsp_ready high outside HOLD SHALL have no effect.

Reset
REQ-024 rst SHALL force state IDLE, rr_ptr 0, req_ready 0, rsp_valid 0, rsp_id 0, rsp_prod 0, busy 0, immediately and independent of clk.
REQ-025 rst during CALC or HOLD SHALL discard the pending result; no rsp_valid after release until a new grant.

Configuration
REQ-026 Macro MUL_SHARE_STATS_EN SHALL, when defined, add port stat_cnt  output  16  count of completed HOLD handshakes, saturating at 0xFFFF, reset to 0.
REQ-027 Without MUL_SHARE_STATS_EN, port stat_cnt and its counter SHALL be absent; all other behaviour identical.

Structure
REQ-028 Package mul_share_pkg SHALL hold OPW default, product width, state typedef (IDLE/CALC/HOLD).
REQ-029 Round-robin selection SHALL be a sub-module rr_pick (inputs valid vector, rr_ptr; outputs grant index and any-valid).

Verification
REQ-030 Only req_valid[1], a=63, b=63 at T -> req_ready=0010 at T, rsp_valid at T+2, rsp_id=1, rsp_prod=3969.
REQ-031 All four valid from reset, rsp_ready=1 -> grants in order 0,1,2,3, then 0; each issue 3 cycles apart.
REQ-032 rsp_ready held low 5 cycles in HOLD with a=5,b=7 -> rsp_valid and rsp_prod=35 stable, req_ready zero throughout.
REQ-033 rst pulsed in CALC -> rsp_valid, busy, rsp_prod 0 immediately; next grant starts from index 0.
REQ-034 a=0,b=45 on requester 3 -> rsp_prod=0, rsp_id=3; a=32,b=2 -> rsp_prod=64.
REQ-035 With MUL_SHARE_STATS_EN, 10 completed transactions -> stat_cnt=10; forced 0xFFFF plus one more -> stays 0xFFFF.

Source files
------------

// File: rtl/mul_share_pkg.sv
// Shared definitions for the time-multiplexed multiplier arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: default operand width, product-width helper, FSM state type.
package mul_share_pkg;

  localparam int OPW_DEF   = 6;
  localparam int PRODW_DEF = 2 * OPW_DEF;

  // Full-precision unsigned product width for a given operand width.
  function automatic int prod_w(input int opw);
    return 2 * opw;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/mul_share_arb_rr_pick.sv
// Round-robin picker: first set bit of valid at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a pick is consumed.
//
// Ports:
//   valid  - request vector
//   ptr    - index where the search starts
//   grant  - winning index (0 when nothing is valid)
//   any    - at least one bit of valid is set
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDW-1:0]   ptr,
  output logic [IDW-1:0]   grant,
  output logic             any
);

  // Walk the offsets from farthest to nearest so the nearest valid
  // index at or above ptr is the last one written and therefore wins.
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    any   = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (valid[IDW'(idx)]) begin
        grant = IDW'(idx);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_share_arb.sv
// One unsigned multiplier shared by N_REQ requesters under round-robin.
// Latency: accept in cycle T, rsp_valid in T+2; one operation every 3 cycles min.
// Backpressure: result held in HOLD until rsp_ready; req_ready stays 0 meanwhile.
//
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   req_valid/req_ready   - per-requester handshake (req_ready one-hot or zero)
//   req_a/req_b           - packed operands, requester i at [i*OPW +: OPW]
//   rsp_valid/rsp_ready   - result handshake
//   rsp_id/rsp_prod       - owner index and full-width product
//   busy                  - high whenever the FSM is not idle
//   stat_cnt              - completed results, saturating (MUL_SHARE_STATS_EN only)
module mul_share_arb
  import mul_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int OPW   = OPW_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_REQ-1:0]                       req_valid,
  output logic [N_REQ-1:0]                       req_ready,
  input  logic [N_REQ*OPW-1:0]                   req_a,
  input  logic [N_REQ*OPW-1:0]                   req_b,
  output logic                                   rsp_valid,
  input  logic                                   rsp_ready,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] rsp_id,
  output logic [2*OPW-1:0]                       rsp_prod,
`ifdef MUL_SHARE_STATS_EN
  output logic [15:0]                            stat_cnt,
`endif
  output logic                                   busy
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW  = prod_w(OPW);

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic [OPW-1:0]   lat_a;
  logic [OPW-1:0]   lat_b;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_idx),
    .any   (pick_any)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any)  state_nxt = CALC;
      CALC:                   state_nxt = HOLD;
      HOLD:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Outputs. req_ready is also gated by rst so it drops the moment reset
  // rises, even while a requester is still presenting a valid.
  always_comb begin
    req_ready = '0;
    rsp_valid = (state == HOLD);
    busy      = (state != IDLE);
    if (state == IDLE && pick_any && !rst)
      req_ready[pick_idx] = 1'b1;
  end

  // Datapath: operands and owner are captured on grant, the product is
  // registered in CALC and then held untouched through HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      lat_a    <= '0;
      lat_b    <= '0;
      rsp_id   <= '0;
      rsp_prod <= '0;
    end else begin
      if (state == IDLE && pick_any) begin
        lat_a  <= req_a[pick_idx*OPW +: OPW];
        lat_b  <= req_b[pick_idx*OPW +: OPW];
        rsp_id <= pick_idx;
        rr_ptr <= (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1;
      end
      if (state == CALC)
        rsp_prod <= PW'(lat_a) * PW'(lat_b);
    end
  end

`ifdef MUL_SHARE_STATS_EN
  logic [15:0] stat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stat_q <= '0;
    else if (state == HOLD && rsp_ready && stat_q != 16'hFFFF)
      stat_q <= stat_q + 16'd1;
  end

  assign stat_cnt = stat_q;
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb: scenario tasks with inline checks,
// plus a response scoreboard fed at grant time and drained on handshakes.
module tb_mul_share_arb;

  localparam int N   = 4;
  localparam int OPW = 6;

  typedef struct packed {
    logic [1:0]  id;
    logic [11:0] prod;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*OPW-1:0] req_a;
  logic [N*OPW-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [11:0]    rsp_prod;
  logic           busy;
`ifdef MUL_SHARE_STATS_EN
  logic [15:0]    stat_cnt;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mul_share_arb #(.N_REQ(N), .OPW(OPW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
`ifdef MUL_SHARE_STATS_EN
    .stat_cnt  (stat_cnt),
`endif
    .busy      (busy)
  );

  // Scoreboard drain: every accepted response must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      exp_t e;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got id=%0d prod=%0d, required no response", rsp_id, rsp_prod);
      end else begin
        e = sb.pop_front();
        if ({rsp_id, rsp_prod} !== e) begin
          n_bad++;
          $display("FAIL sb_rsp: got id=%0d prod=%0d, required id=%0d prod=%0d",
                   rsp_id, rsp_prod, e.id, e.prod);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [5:0] a, input logic [5:0] b);
    req_a[i*OPW +: OPW] = a;
    req_b[i*OPW +: OPW] = b;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1; req_a = '0; req_b = '0;
    #3;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_id, rsp_prod, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got ready=%b vld=%b id=%0d prod=%0d busy=%b, required all 0",
               req_ready, rsp_valid, rsp_id, rsp_prod, busy);
    end
    cyc(); cyc();
    n_cmp++;
    if (busy !== 1'b0 || req_ready !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_held: got busy=%b ready=%b, required 0/0000", busy, req_ready);
    end
    req_valid = '0; rsp_ready = 1'b0;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_single();
    set_ops(1, 6'd63, 6'd63);
    req_valid = 4'b0010;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_bad++; $display("FAIL single_ready: got %b, required 0010", req_ready);
    end
    sb.push_back('{id: 2'd1, prod: 12'd3969});
    cyc();
    req_valid = '0;
    n_cmp++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 4'b0) begin
      n_bad++;
      $display("FAIL single_calc: got vld=%b busy=%b ready=%b, required 0/1/0000", rsp_valid, busy, req_ready);
    end
    cyc();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_prod !== 12'd3969) begin
      n_bad++;
      $display("FAIL single_t2: got vld=%b id=%0d prod=%0d, required 1/1/3969", rsp_valid, rsp_id, rsp_prod);
    end
    rsp_ready = 1'b1;
    cyc();
    n_cmp++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL single_done: got vld=%b busy=%b, required 0/0", rsp_valid, busy);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    time t_prev;
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    for (int i = 0; i < N; i++) set_ops(i, 6'($urandom_range(63)), 6'($urandom_range(63)));
    req_valid = 4'hF; rsp_ready = 1'b1;
    t_prev = 0;
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % N;
      #1;
      n_cmp++;
      if (req_ready !== (4'b0001 << g)) begin
        n_bad++; $display("FAIL rr_grant%0d: got %b, required %b", k, req_ready, 4'b0001 << g);
      end
      if (k > 0) begin
        n_cmp++;
        if ($time - t_prev != 30) begin
          n_bad++; $display("FAIL rr_interval%0d: got %0t, required 30", k, $time - t_prev);
        end
      end
      t_prev = $time;
      sb.push_back('{id: 2'(g), prod: 12'(req_a[g*OPW +: OPW]) * 12'(req_b[g*OPW +: OPW])});
      cyc();
      set_ops(g, 6'($urandom_range(63)), 6'($urandom_range(63)));
      n_cmp++;
      if (req_ready !== 4'b0 || rsp_valid !== 1'b0) begin
        n_bad++; $display("FAIL rr_calc%0d: got ready=%b vld=%b, required 0000/0", k, req_ready, rsp_valid);
      end
      cyc();
      n_cmp++;
      if (req_ready !== 4'b0 || rsp_valid !== 1'b1) begin
        n_bad++; $display("FAIL rr_hold%0d: got ready=%b vld=%b, required 0000/1", k, req_ready, rsp_valid);
      end
      cyc();
    end
    req_valid = '0; rsp_ready = 1'b0;
  endtask

  task automatic test_hold_stall();
    // rr_ptr is 1 here; only requester 0 valid, so the search wraps to 0.
    for (int i = 1; i < N; i++) set_ops(i, 6'($urandom_range(63)), 6'($urandom_range(63)));
    set_ops(0, 6'd5, 6'd7);
    req_valid = 4'b0001;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++; $display("FAIL stall_grant: got %b, required 0001", req_ready);
    end
    sb.push_back('{id: 2'd0, prod: 12'd35});
    cyc();
    req_valid = 4'b1110;
    cyc();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_prod !== 12'd35 || rsp_id !== 2'd0 || req_ready !== 4'b0) begin
        n_bad++;
        $display("FAIL stall_hold%0d: got vld=%b prod=%0d id=%0d ready=%b, required 1/35/0/0000",
                 i, rsp_valid, rsp_prod, rsp_id, req_ready);
      end
      cyc();
    end
    rsp_ready = 1'b1;
    cyc();
    // Waiting requesters were not dropped: 1 is next from rr_ptr=1.
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_bad++; $display("FAIL stall_waiter: got %b, required 0010", req_ready);
    end
    sb.push_back('{id: 2'd1, prod: 12'(req_a[1*OPW +: OPW]) * 12'(req_b[1*OPW +: OPW])});
    cyc();
    req_valid = '0;
    cyc(); cyc();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_calc();
    // rr_ptr is 2 here.
    set_ops(2, 6'd9, 6'd9);
    req_valid = 4'b0100;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_bad++; $display("FAIL rstc_grant: got %b, required 0100", req_ready);
    end
    cyc();
    req_valid = '0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_prod !== 12'd0 || req_ready !== 4'b0) begin
      n_bad++;
      $display("FAIL rstc_async: got vld=%b busy=%b prod=%0d ready=%b, required 0/0/0/0000",
               rsp_valid, busy, rsp_prod, req_ready);
    end
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL rstc_discard%0d: got vld=%b busy=%b, required 0/0", i, rsp_valid, busy);
      end
    end
    for (int i = 0; i < N; i++) set_ops(i, 6'($urandom_range(63)), 6'($urandom_range(63)));
    req_valid = 4'hF;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++; $display("FAIL rstc_ptr: got %b, required 0001", req_ready);
    end
    sb.push_back('{id: 2'd0, prod: 12'(req_a[0 +: OPW]) * 12'(req_b[0 +: OPW])});
    rsp_ready = 1'b1;
    cyc();
    req_valid = '0;
    cyc(); cyc();
    rsp_ready = 1'b0;
  endtask

  task automatic test_edge_operands();
    // rr_ptr is 1 here.
    int          ids [2] = '{3, 2};
    logic [5:0]  as  [2] = '{6'd0, 6'd32};
    logic [5:0]  bs  [2] = '{6'd45, 6'd2};
    logic [11:0] ps  [2] = '{12'd0, 12'd64};
    for (int k = 0; k < 2; k++) begin
      set_ops(ids[k], as[k], bs[k]);
      req_valid = 4'b0001 << ids[k];
      #1;
      n_cmp++;
      if (req_ready !== (4'b0001 << ids[k])) begin
        n_bad++; $display("FAIL edge_grant%0d: got %b, required %b", k, req_ready, 4'b0001 << ids[k]);
      end
      sb.push_back('{id: 2'(ids[k]), prod: ps[k]});
      rsp_ready = 1'b1;
      cyc();
      req_valid = '0;
      cyc();
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(ids[k]) || rsp_prod !== ps[k]) begin
        n_bad++;
        $display("FAIL edge_rsp%0d: got vld=%b id=%0d prod=%0d, required 1/%0d/%0d",
                 k, rsp_valid, rsp_id, rsp_prod, ids[k], ps[k]);
      end
      cyc();
    end
    rsp_ready = 1'b0;
  endtask

`ifdef MUL_SHARE_STATS_EN
  task automatic test_stats();
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    rsp_ready = 1'b1;
    set_ops(0, 6'd3, 6'd4);
    for (int k = 0; k < 10; k++) begin
      req_valid = 4'b0001;
      sb.push_back('{id: 2'd0, prod: 12'd12});
      cyc();
      req_valid = '0;
      cyc(); cyc();
    end
    n_cmp++;
    if (stat_cnt !== 16'd10) begin
      n_bad++; $display("FAIL stats_10: got %0d, required 10", stat_cnt);
    end
    force dut.stat_q = 16'hFFFF;
    #1;
    release dut.stat_q;
    req_valid = 4'b0001;
    sb.push_back('{id: 2'd0, prod: 12'd12});
    cyc();
    req_valid = '0;
    cyc(); cyc();
    n_cmp++;
    if (stat_cnt !== 16'hFFFF) begin
      n_bad++; $display("FAIL stats_sat: got %h, required ffff", stat_cnt);
    end
    rsp_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_hold_stall();
    test_reset_calc();
    test_edge_operands();
`ifdef MUL_SHARE_STATS_EN
    test_stats();
`endif
    cyc(); cyc();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL sb_drained: got %0d outstanding, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
